vga_timing_gen: RTL and testbench

//  640x480@60 raster timing generator, clocked directly by the 25 MHz pixel clock.

---
 rtl/vga_timing_gen.sv | 109 ++++++++++
 tb/tb_vga_timing_gen.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_timing_gen.sv
// 640x480@60 raster timing generator running on the pixel clock.
// Sync and blank are delayed to line up with the sprite ROM and colour register latency.
module vga_timing_gen #(
   parameter int H_VISIBLE   = 640,
   parameter int H_FRONT     = 16,
   parameter int H_SYNC      = 96,
   parameter int H_BACK      = 48,
   parameter int V_VISIBLE   = 480,
   parameter int V_FRONT     = 10,
   parameter int V_SYNC      = 2,
   parameter int V_BACK      = 33,
   parameter int BLANK_DELAY = 1,
   parameter int SYNC_DELAY  = 2
) (
   input  logic       vga_clk,
   input  logic       reset,
   output logic [9:0] DrawX,
   output logic [9:0] DrawY,
   output logic       blank,
   output logic       hs,
   output logic       vs,
   output logic       frame_tick
);

   localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
   localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

   localparam logic [9:0] H_LAST       = 10'(H_TOTAL - 1);
   localparam logic [9:0] V_LAST       = 10'(V_TOTAL - 1);
   localparam logic [9:0] H_VIS        = 10'(H_VISIBLE);
   localparam logic [9:0] V_VIS        = 10'(V_VISIBLE);
   localparam logic [9:0] H_SYNC_START = 10'(H_VISIBLE + H_FRONT);
   localparam logic [9:0] H_SYNC_END   = 10'(H_VISIBLE + H_FRONT + H_SYNC);
   localparam logic [9:0] V_SYNC_START = 10'(V_VISIBLE + V_FRONT);
   localparam logic [9:0] V_SYNC_END   = 10'(V_VISIBLE + V_FRONT + V_SYNC);

   logic [9:0] r_hCnt;
   logic [9:0] r_vCnt;
   logic       r_frameTick;
   logic       w_blankRaw;
   logic       w_hsRaw;
   logic       w_vsRaw;

   // The tick is registered off the last pixel, so it is seen alongside the (0,0) of the next frame.
   always_ff @(posedge vga_clk) begin
      if (reset) begin
         r_hCnt      <= '0;
         r_vCnt      <= '0;
         r_frameTick <= 1'b0;
      end else begin
         r_frameTick <= (r_hCnt == H_LAST) && (r_vCnt == V_LAST);
         if (r_hCnt == H_LAST) begin
            r_hCnt <= '0;
            if (r_vCnt == V_LAST) begin
               r_vCnt <= '0;
            end else begin
               r_vCnt <= r_vCnt + 10'd1;
            end
         end else begin
            r_hCnt <= r_hCnt + 10'd1;
         end
      end
   end

   assign w_blankRaw = (r_hCnt < H_VIS) && (r_vCnt < V_VIS);
   assign w_hsRaw    = ~((r_hCnt >= H_SYNC_START) && (r_hCnt < H_SYNC_END));
   assign w_vsRaw    = ~((r_vCnt >= V_SYNC_START) && (r_vCnt < V_SYNC_END));

   assign DrawX      = r_hCnt;
   assign DrawY      = r_vCnt;
   assign frame_tick = r_frameTick;

   // A zero-length delay collapses to a wire; otherwise a shift register preloaded with the idle level.
   generate
      if (BLANK_DELAY == 0) begin : gBlankDirect
         assign blank = w_blankRaw;
      end else begin : gBlankPipe
         logic [BLANK_DELAY-1:0] r_blankPipe;
         always_ff @(posedge vga_clk) begin
            if (reset) begin
               r_blankPipe <= '0;
            end else begin
               r_blankPipe <= (r_blankPipe << 1) | BLANK_DELAY'(w_blankRaw);
            end
         end
         assign blank = r_blankPipe[BLANK_DELAY-1];
      end

      if (SYNC_DELAY == 0) begin : gSyncDirect
         assign hs = w_hsRaw;
         assign vs = w_vsRaw;
      end else begin : gSyncPipe
         logic [SYNC_DELAY-1:0] r_hsPipe;
         logic [SYNC_DELAY-1:0] r_vsPipe;
         always_ff @(posedge vga_clk) begin
            if (reset) begin
               r_hsPipe <= '1;
               r_vsPipe <= '1;
            end else begin
               r_hsPipe <= (r_hsPipe << 1) | SYNC_DELAY'(w_hsRaw);
               r_vsPipe <= (r_vsPipe << 1) | SYNC_DELAY'(w_vsRaw);
            end
         end
         assign hs = r_hsPipe[SYNC_DELAY-1];
         assign vs = r_vsPipe[SYNC_DELAY-1];
      end
   endgenerate

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: default, zero-delay and small-raster instances share one clock and reset,
// each compared every cycle against an arithmetic model driven by the cycle count since reset.
module tb_vga_timing_gen;

   logic       clk   = 1'b0;
   logic       reset = 1'b1;
   logic [9:0] xA, yA, xZ, yZ, xS, yS;
   logic       blA, hsA, vsA, tkA;
   logic       blZ, hsZ, vsZ, tkZ;
   logic       blS, hsS, vsS, tkS;
   int         t      = 0;
   int         checks = 0;
   int         errors = 0;

   always #20 clk = ~clk;

   vga_timing_gen dutA (
      .vga_clk(clk), .reset(reset), .DrawX(xA), .DrawY(yA),
      .blank(blA), .hs(hsA), .vs(vsA), .frame_tick(tkA)
   );

   vga_timing_gen #(.BLANK_DELAY(0), .SYNC_DELAY(0)) dutZ (
      .vga_clk(clk), .reset(reset), .DrawX(xZ), .DrawY(yZ),
      .blank(blZ), .hs(hsZ), .vs(vsZ), .frame_tick(tkZ)
   );

   vga_timing_gen #(
      .H_VISIBLE(20), .H_FRONT(2), .H_SYNC(3), .H_BACK(5),
      .V_VISIBLE(8), .V_FRONT(2), .V_SYNC(2), .V_BACK(3),
      .BLANK_DELAY(3), .SYNC_DELAY(5)
   ) dutS (
      .vga_clk(clk), .reset(reset), .DrawX(xS), .DrawY(yS),
      .blank(blS), .hs(hsS), .vs(vsS), .frame_tick(tkS)
   );

   // Expected outputs tt clocks after reset: position from division, delayed terms from position tt-N.
   function automatic logic [23:0] model(int tt, int hv, int hf, int hsw, int hb,
                                         int vv, int vf, int vsw, int vb, int bd, int sd);
      int ht, vt, u;
      logic bl, h, v, tk;
      logic [9:0] x, y;
      ht = hv + hf + hsw + hb;
      vt = vv + vf + vsw + vb;
      x  = 10'(tt % ht);
      y  = 10'((tt / ht) % vt);
      bl = 1'b0;
      h  = 1'b1;
      v  = 1'b1;
      if (tt >= bd) begin
         u  = tt - bd;
         bl = ((u % ht) < hv) && (((u / ht) % vt) < vv);
      end
      if (tt >= sd) begin
         u = tt - sd;
         h = !(((u % ht) >= hv + hf) && ((u % ht) < hv + hf + hsw));
         v = !((((u / ht) % vt) >= vv + vf) && (((u / ht) % vt) < vv + vf + vsw));
      end
      tk = (tt > 0) && (tt % (ht * vt) == 0);
      return {x, y, bl, h, v, tk};
   endfunction

   function automatic logic [23:0] expVec(int k, int tt);
      case (k)
         0:       return model(tt, 640, 16, 96, 48, 480, 10, 2, 33, 1, 2);
         1:       return model(tt, 640, 16, 96, 48, 480, 10, 2, 33, 0, 0);
         default: return model(tt, 20, 2, 3, 5, 8, 2, 2, 3, 3, 5);
      endcase
   endfunction

   function automatic logic [23:0] obsVec(int k);
      case (k)
         0:       return {xA, yA, blA, hsA, vsA, tkA};
         1:       return {xZ, yZ, blZ, hsZ, vsZ, tkZ};
         default: return {xS, yS, blS, hsS, vsS, tkS};
      endcase
   endfunction

   task automatic tick();
      @(posedge clk);
      if (reset) t = 0;
      else t++;
      @(negedge clk);
   endtask

   task automatic pulseReset();
      reset = 1'b1;
      tick();
      reset = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick();
         checks++;
         if ({xA, yA, blA, hsA, vsA, tkA} !== 24'h000006) begin
            errors++;
            $display("[TB] FAIL reset_hold cycle=%0d got=%h expected=%h", i, {xA, yA, blA, hsA, vsA, tkA}, 24'h000006);
         end
         for (int k = 1; k < 3; k++) begin
            checks++;
            if (obsVec(k) !== expVec(k, t)) begin
               errors++;
               $display("[TB] FAIL reset_hold dut%0d got=%h expected=%h", k, obsVec(k), expVec(k, t));
            end
         end
      end
      reset = 1'b0;
      tick();
      checks++;
      if (xA !== 10'd1 || yA !== 10'd0) begin
         errors++;
         $display("[TB] FAIL reset_release got x=%0d y=%0d expected x=1 y=0", xA, yA);
      end
   endtask

   task automatic test_line();
      int blankCount;
      blankCount = 0;
      pulseReset();
      for (int i = 0; i < 1000; i++) begin
         tick();
         if (t <= 800 && blA === 1'b1) blankCount++;
         if (t == 800) begin
            checks++;
            if (xA !== 10'd0 || yA !== 10'd1) begin
               errors++;
               $display("[TB] FAIL line_wrap got x=%0d y=%0d expected x=0 y=1", xA, yA);
            end
         end
         for (int k = 0; k < 3; k++) begin
            checks++;
            if (obsVec(k) !== expVec(k, t)) begin
               errors++;
               if (errors < 20) $display("[TB] FAIL line dut%0d t=%0d got=%h expected=%h", k, t, obsVec(k), expVec(k, t));
            end
         end
      end
      checks++;
      if (blankCount != 640) begin
         errors++;
         $display("[TB] FAIL line_blank_count got=%0d expected=640", blankCount);
      end
   endtask

   task automatic test_hsync();
      int lowA, lowZ, firstA, firstZ, guard;
      lowA = 0; lowZ = 0; firstA = -1; firstZ = -1; guard = 0;
      while (xA !== 10'd0 && guard < 1000) begin
         tick();
         guard++;
      end
      checks++;
      if (xA !== 10'd0) begin
         errors++;
         $display("[TB] FAIL hsync_align got x=%0d expected x=0 within 1000 clocks", xA);
      end
      for (int i = 0; i < 800; i++) begin
         if (hsA === 1'b0) begin
            if (firstA < 0) firstA = int'(xA);
            lowA++;
         end
         if (hsZ === 1'b0) begin
            if (firstZ < 0) firstZ = int'(xZ);
            lowZ++;
         end
         for (int k = 0; k < 3; k++) begin
            checks++;
            if (obsVec(k) !== expVec(k, t)) begin
               errors++;
               if (errors < 20) $display("[TB] FAIL hsync dut%0d t=%0d got=%h expected=%h", k, t, obsVec(k), expVec(k, t));
            end
         end
         tick();
      end
      checks += 4;
      if (lowA != 96) begin
         errors++;
         $display("[TB] FAIL hsync_width got=%0d expected=96", lowA);
      end
      if (firstA != 658) begin
         errors++;
         $display("[TB] FAIL hsync_start got=%0d expected=658", firstA);
      end
      if (lowZ != 96) begin
         errors++;
         $display("[TB] FAIL hsync_width_nodelay got=%0d expected=96", lowZ);
      end
      if (firstZ != 656) begin
         errors++;
         $display("[TB] FAIL hsync_start_nodelay got=%0d expected=656", firstZ);
      end
   endtask

   task automatic test_frame();
      int ticks, lastTick, runLen, runs, maxY;
      ticks = 0; lastTick = 0; runLen = 0; runs = 0; maxY = 0;
      pulseReset();
      for (int i = 0; i < 1370; i++) begin
         tick();
         if (int'(yS) > maxY) maxY = int'(yS);
         if (tkS === 1'b1) begin
            ticks++;
            checks++;
            if (t - lastTick != 450) begin
               errors++;
               $display("[TB] FAIL frame_tick_interval got=%0d expected=450", t - lastTick);
            end
            lastTick = t;
         end
         if (vsS === 1'b0) begin
            runLen++;
         end else if (runLen > 0) begin
            runs++;
            checks++;
            if (runLen != 60) begin
               errors++;
               $display("[TB] FAIL vsync_width got=%0d expected=60", runLen);
            end
            runLen = 0;
         end
         for (int k = 0; k < 3; k++) begin
            checks++;
            if (obsVec(k) !== expVec(k, t)) begin
               errors++;
               if (errors < 20) $display("[TB] FAIL frame dut%0d t=%0d got=%h expected=%h", k, t, obsVec(k), expVec(k, t));
            end
         end
      end
      checks += 3;
      if (ticks != 3) begin
         errors++;
         $display("[TB] FAIL frame_tick_count got=%0d expected=3", ticks);
      end
      if (runs != 3) begin
         errors++;
         $display("[TB] FAIL vsync_count got=%0d expected=3", runs);
      end
      if (maxY != 14) begin
         errors++;
         $display("[TB] FAIL frame_max_y got=%0d expected=14", maxY);
      end
   endtask

   task automatic test_mid_reset();
      int line, guard;
      line  = int'($urandom_range(1, 3));
      guard = 0;
      pulseReset();
      while (!(xA === 10'd300 && yA === 10'(line)) && guard < 4000) begin
         tick();
         guard++;
      end
      checks++;
      if (xA !== 10'd300 || yA !== 10'(line)) begin
         errors++;
         $display("[TB] FAIL midreset_reach got x=%0d y=%0d expected x=300 y=%0d", xA, yA, line);
      end
      reset = 1'b1;
      tick();
      reset = 1'b0;
      checks++;
      if ({xA, yA, blA, hsA, vsA, tkA} !== 24'h000006) begin
         errors++;
         $display("[TB] FAIL midreset_state got=%h expected=%h", {xA, yA, blA, hsA, vsA, tkA}, 24'h000006);
      end
      for (int i = 0; i < 1000; i++) begin
         tick();
         for (int k = 0; k < 3; k++) begin
            checks++;
            if (obsVec(k) !== expVec(k, t)) begin
               errors++;
               if (errors < 20) $display("[TB] FAIL midreset dut%0d t=%0d got=%h expected=%h", k, t, obsVec(k), expVec(k, t));
            end
         end
      end
   endtask

   task automatic test_random();
      int n, r;
      for (int it = 0; it < 8; it++) begin
         n = int'($urandom_range(1, 1200));
         r = int'($urandom_range(1, 3));
         for (int i = 0; i < n + r; i++) begin
            reset = (i >= n);
            tick();
            for (int k = 0; k < 3; k++) begin
               checks++;
               if (obsVec(k) !== expVec(k, t)) begin
                  errors++;
                  if (errors < 20) $display("[TB] FAIL random dut%0d t=%0d got=%h expected=%h", k, t, obsVec(k), expVec(k, t));
               end
            end
         end
         reset = 1'b0;
      end
   endtask

   initial begin
      test_reset();
      test_line();
      test_hsync();
      test_frame();
      test_mid_reset();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
